// File: rtl/array_output_writer_pkg.sv
// Shared definitions for the array output writer: controller state encoding
// and the accumulator-to-datapath requantisation rule.
package array_output_writer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      WRITE   = 2'd2,
      DONE    = 2'd3
   } state_t;

   // Arithmetic right shift by the fractional-bit difference (floor toward
   // -inf), then clamp to the signed range of a width-bit datapath word.
   // Works on a wide signed value so any accumulator width up to 64 fits;
   // the caller casts the result down to its datapath width.
   function automatic logic signed [63:0] requant(input logic signed [63:0] x,
                                                  input int width,
                                                  input int decimal);
      logic signed [63:0] y;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      y  = x >>> decimal;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (y > hi)
         y = hi;
      else if (y < lo)
         y = lo;
      return y;
   endfunction

endpackage

// File: rtl/array_output_writer_requant.sv
// One column lane: combinational shift + saturate of an accumulator result
// into a datapath word.
module output_requant
   import array_output_writer_pkg::*;
#(
   parameter int ACC_W   = 16,
   parameter int WIDTH   = 8,
   parameter int DECIMAL = 4
) (
   input  logic [ACC_W-1:0] acc,
   output logic [WIDTH-1:0] q
);

   // Sign-extend the accumulator and reuse the shared requant rule.
   assign q = WIDTH'(requant(64'(signed'(acc)), WIDTH, DECIMAL));

endmodule

// File: rtl/array_output_writer.sv
// Captures skewed per-column results from the bottom of the systolic array,
// requantises them at capture time, then writes the ROWS x COLS tile
// row-major into data memory and pulses output_finish.
module array_output_writer
   import array_output_writer_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DECIMAL   = 4,
   parameter int ACC_W     = 16,
   parameter int ROWS      = 4,
   parameter int COLS      = 4,
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 40
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [COLS*ACC_W-1:0] outs_array,
   input  logic [COLS-1:0]       out_valid,
   output logic                  mem_ena,
   output logic                  mem_wea,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [WIDTH-1:0]      mem_din,
   output logic                  busy,
   output logic                  output_finish,
   output logic                  overflow
);

   localparam int NUM   = ROWS * COLS;
   localparam int CNT_W = $clog2(ROWS + 1);
   localparam int IDX_W = $clog2(NUM + 1);
   localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;

   state_t state, next_state;

   logic [COLS-1:0][CNT_W-1:0]           cnt;
   logic [COLS-1:0]                      full;
   logic [COLS-1:0]                      cap_en;
   logic                                 ovf_hit;
   logic [COLS-1:0][WIDTH-1:0]           rq;
   logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] tile;
   logic [IDX_W-1:0]                     widx;

   // Per-column requantisers.
   genvar g;
   for (g = 0; g < COLS; g++) begin : g_rq
      output_requant #(
         .ACC_W  (ACC_W),
         .WIDTH  (WIDTH),
         .DECIMAL(DECIMAL)
      ) u_rq (
         .acc(outs_array[g*ACC_W +: ACC_W]),
         .q  (rq[g])
      );
   end

   // Column status: a column accepts a strobe only while it has room.
   always_comb begin
      full    = '0;
      cap_en  = '0;
      ovf_hit = 1'b0;
      for (int c = 0; c < COLS; c++) begin
         full[c]   = (cnt[c] == CNT_W'(ROWS));
         cap_en[c] = (state == CAPTURE) && out_valid[c] && !full[c];
         if ((state == CAPTURE) && out_valid[c] && full[c])
            ovf_hit = 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state: the WRITE decision looks at registered counters, so the
   // burst starts one cycle after the last column's counter fills.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = CAPTURE;
         CAPTURE: if (&full) next_state = WRITE;
         WRITE:   if (widx == IDX_W'(NUM)) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Tile buffer: each column lane drops its value at its own row pointer.
   always_ff @(posedge clk) begin
      for (int c = 0; c < COLS; c++) begin
         if (cap_en[c])
            tile[RW'(cnt[c])][c] <= rq[c];
      end
   end

   // Counters, overflow flag and registered memory-port outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt           <= '0;
         overflow      <= 1'b0;
         widx          <= '0;
         mem_ena       <= 1'b0;
         mem_wea       <= 1'b0;
         mem_addr      <= '0;
         mem_din       <= '0;
         output_finish <= 1'b0;
      end else begin
         mem_ena       <= (next_state == WRITE);
         mem_wea       <= (next_state == WRITE);
         output_finish <= (next_state == DONE);
         if (next_state == WRITE) begin
            mem_addr <= ADDR_W'(BASE_ADDR) + ADDR_W'(widx);
            mem_din  <= tile[RW'(int'(widx) / COLS)][CW'(int'(widx) % COLS)];
            widx     <= widx + IDX_W'(1);
         end
         if ((state == IDLE) && start) begin
            cnt      <= '0;
            overflow <= 1'b0;
            widx     <= '0;
         end else if (state == CAPTURE) begin
            for (int c = 0; c < COLS; c++) begin
               if (cap_en[c])
                  cnt[c] <= cnt[c] + CNT_W'(1);
            end
            if (ovf_hit)
               overflow <= 1'b1;
         end
      end
   end

   // Busy covers the whole capture/write window.
   assign busy = (state == CAPTURE) || (state == WRITE);

endmodule

// File: tb/tb_array_output_writer.sv
// Bench for array_output_writer: directed tiles from the test plan plus
// randomized tiles, all checked cycle by cycle against a behavioural model.
module tb_array_output_writer;

   localparam int WIDTH = 8, DECIMAL = 4, ACC_W = 16, ROWS = 4, COLS = 4;
   localparam int ADDR_W = 8, BASE_ADDR = 40, NUM = ROWS * COLS;

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic                  start = 1'b0;
   logic [COLS*ACC_W-1:0] outs_array = '0;
   logic [COLS-1:0]       out_valid = '0;
   logic                  mem_ena, mem_wea, busy, output_finish, overflow;
   logic [ADDR_W-1:0]     mem_addr;
   logic [WIDTH-1:0]      mem_din;

   array_output_writer #(
      .WIDTH(WIDTH), .DECIMAL(DECIMAL), .ACC_W(ACC_W), .ROWS(ROWS),
      .COLS(COLS), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .outs_array(outs_array),
      .out_valid(out_valid), .mem_ena(mem_ena), .mem_wea(mem_wea),
      .mem_addr(mem_addr), .mem_din(mem_din), .busy(busy),
      .output_finish(output_finish), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int vectors = 0, errors = 0;
   int wr_cnt = 0, fin_cnt = 0;
   int first_wr_cyc = -1, last_strobe_cyc = 0;
   int mem_img [256];
   int tv [ROWS][COLS];

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Floor division by 2^DECIMAL written with a modulo, then clamp.
   function automatic int ref_requant(input int x);
      int s, y, hi, lo;
      s  = 1 << DECIMAL;
      hi = (1 << (WIDTH - 1)) - 1;
      lo = -(1 << (WIDTH - 1));
      y  = (x - (((x % s) + s) % s)) / s;
      if (y > hi) y = hi;
      if (y < lo) y = lo;
      return y;
   endfunction

   // Behavioural model: phase 0 idle, 1 collecting, 2 writing, 3 finishing.
   int   m_phase = 0, m_k = 0;
   int   m_cnt [COLS] = '{default: 0};
   int   m_tile [ROWS][COLS];
   bit   e_ena = 0, e_fin = 0, e_ovf = 0;
   int   e_addr = 0, e_din = 0;

   task automatic m_emit();
      e_ena  = 1;
      e_addr = (BASE_ADDR + m_k) % (1 << ADDR_W);
      e_din  = m_tile[m_k / COLS][m_k % COLS] & ((1 << WIDTH) - 1);
      m_k++;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0; m_k = 0;
         foreach (m_cnt[c]) m_cnt[c] = 0;
         e_ena = 0; e_fin = 0; e_ovf = 0; e_addr = 0; e_din = 0;
      end else begin
         bit all_in;
         e_ena = 0; e_fin = 0;
         case (m_phase)
            0: if (start) begin
                  m_phase = 1; m_k = 0; e_ovf = 0;
                  foreach (m_cnt[c]) m_cnt[c] = 0;
               end
            1: begin
                  all_in = 1;
                  foreach (m_cnt[c]) if (m_cnt[c] != ROWS) all_in = 0;
                  for (int c = 0; c < COLS; c++) begin
                     if (out_valid[c]) begin
                        if (m_cnt[c] < ROWS) begin
                           m_tile[m_cnt[c]][c] =
                              ref_requant(int'($signed(outs_array[c*ACC_W +: ACC_W])));
                           m_cnt[c]++;
                        end else e_ovf = 1;
                     end
                  end
                  if (all_in) begin m_phase = 2; m_emit(); end
               end
            2: if (m_k == NUM) begin m_phase = 3; e_fin = 1; end
               else m_emit();
            default: m_phase = 0;
         endcase
      end
   end

   // Compare process: every cycle outside reset.
   always @(posedge clk) begin
      #2;
      if (!rst) begin
         chk("mem_ena", int'(mem_ena), int'(e_ena));
         chk("mem_wea", int'(mem_wea), int'(e_ena));
         chk("mem_addr", int'(mem_addr), e_addr);
         chk("mem_din", int'(mem_din), e_din);
         chk("busy", int'(busy), int'(m_phase == 1 || m_phase == 2));
         chk("output_finish", int'(output_finish), int'(e_fin));
         chk("overflow", int'(overflow), int'(e_ovf));
         if (mem_ena && mem_wea) begin
            mem_img[mem_addr] = int'(mem_din);
            wr_cnt++;
            if (first_wr_cyc < 0 && mem_addr == ADDR_W'(BASE_ADDR)) first_wr_cyc = cyc;
         end
         if (output_finish) fin_cnt++;
      end
   end

   task automatic drive(input logic [COLS-1:0] v, input logic [COLS*ACC_W-1:0] d,
                        input bit st);
      @(negedge clk);
      out_valid  = v;
      outs_array = d;
      start      = st;
   endtask

   // Feed tv[][] with column c delayed by c*skew cycles.
   task automatic feed(input int skew, input bit extra, input bit poke);
      int last_t;
      last_t = ROWS - 1 + (COLS - 1) * skew;
      for (int t = 0; t <= last_t; t++) begin
         logic [COLS-1:0]       v;
         logic [COLS*ACC_W-1:0] d;
         v = '0; d = '0;
         for (int c = 0; c < COLS; c++) begin
            int r;
            r = t - c * skew;
            if (r >= 0 && r < ROWS) begin
               v[c] = 1'b1;
               d[c*ACC_W +: ACC_W] = ACC_W'(tv[r][c]);
            end
         end
         if (extra && t == ROWS) begin
            v[0] = 1'b1;
            d[ACC_W-1:0] = 16'h7FFF;
         end
         drive(v, d, poke && t == 1);
         if (t == last_t) last_strobe_cyc = cyc;
      end
      drive('0, '0, 0);
   endtask

   task automatic wait_finish(input int f0, input bit poke);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (poke) start = (i == 3);
         if (fin_cnt != f0) break;
      end
      start = 1'b0;
   endtask

   task automatic run_tile(input int skew, input bit extra, input bit poke);
      int w0, f0;
      first_wr_cyc = -1;
      w0 = wr_cnt; f0 = fin_cnt;
      drive('0, '0, 1);
      feed(skew, extra, poke);
      wait_finish(f0, poke);
      chk("tile_writes", wr_cnt - w0, NUM);
      chk("tile_finish_pulses", fin_cnt - f0, 1);
      @(negedge clk);
      chk("busy_after_tile", int'(busy), 0);
   endtask

   task automatic basic_data();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            tv[r][c] = (r * 4 + c + 1) << 4;
   endtask

   task automatic check_basic_image(input string nm);
      for (int i = 0; i < NUM; i++) chk(nm, mem_img[BASE_ADDR + i], i + 1);
   endtask

   task automatic random_tile();
      int sent [COLS];
      int w0, f0;
      logic [COLS-1:0]       v;
      logic [COLS*ACC_W-1:0] d;
      bit done;
      w0 = wr_cnt; f0 = fin_cnt;
      foreach (sent[c]) sent[c] = 0;
      // junk strobes on the start cycle must be ignored
      drive(COLS'($urandom), {$urandom, $urandom}, 1);
      for (int n = 0; n < 200; n++) begin
         v = '0; d = '0;
         for (int c = 0; c < COLS; c++) begin
            int val;
            case ($urandom_range(0, 2))
               0:       val = int'($urandom_range(0, 65535));
               1:       val = int'($urandom_range(0, 4095)) - 2048;
               default: val = int'($urandom_range(0, 63)) - 32;
            endcase
            d[c*ACC_W +: ACC_W] = ACC_W'(val);
            if (sent[c] < ROWS && $urandom_range(0, 1) == 1) begin
               v[c] = 1'b1; sent[c]++;
            end else if (sent[c] == ROWS && $urandom_range(0, 29) == 0)
               v[c] = 1'b1;
         end
         drive(v, d, 0);
         done = 1;
         foreach (sent[c]) if (sent[c] != ROWS) done = 0;
         if (done) break;
      end
      drive('0, '0, 0);
      wait_finish(f0, 0);
      chk("rand_writes", wr_cnt - w0, NUM);
      chk("rand_finish", fin_cnt - f0, 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end expected end");
      $fatal(1, "watchdog");
   end

   initial begin
      int f0;
      bit hit;
      foreach (mem_img[i]) mem_img[i] = -1;
      #1 rst = 1'b1;
      #2;
      chk("reset_ena", int'(mem_ena), 0);
      chk("reset_wea", int'(mem_wea), 0);
      chk("reset_addr", int'(mem_addr), 0);
      chk("reset_din", int'(mem_din), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_finish", int'(output_finish), 0);
      chk("reset_overflow", int'(overflow), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // model pins
      chk("model_rq_sat_hi", ref_requant(16'h0900), 127);
      chk("model_rq_sat_lo", ref_requant(-4096), -128);
      chk("model_rq_floor", ref_requant(-23), -2);

      // basic tile
      basic_data();
      run_tile(0, 0, 0);
      check_basic_image("basic_mem");

      // skewed arrival
      foreach (mem_img[i]) mem_img[i] = -1;
      run_tile(1, 0, 0);
      check_basic_image("skew_mem");
      chk("skew_first_write_latency", first_wr_cyc - last_strobe_cyc, 2);

      // saturation / rounding
      foreach (tv[r, c]) tv[r][c] = 0;
      tv[0][0] = 16'h0900; tv[1][0] = 16'hF000;
      tv[2][0] = 16'h0017; tv[3][0] = 16'hFFE9;
      run_tile(0, 0, 0);
      chk("sat_0900", mem_img[BASE_ADDR + 0], 8'h7F);
      chk("sat_F000", mem_img[BASE_ADDR + 4], 8'h80);
      chk("rnd_0017", mem_img[BASE_ADDR + 8], 8'h01);
      chk("rnd_FFE9", mem_img[BASE_ADDR + 12], 8'hFE);

      // overflow
      basic_data();
      run_tile(1, 1, 0);
      chk("overflow_sticky", int'(overflow), 1);
      check_basic_image("overflow_mem");

      // reset mid-burst, at the 6th write
      f0 = fin_cnt;
      drive('0, '0, 1);
      feed(0, 0, 0);
      hit = 0;
      for (int i = 0; i < 100; i++) begin
         if (mem_ena && mem_addr == ADDR_W'(BASE_ADDR + 5)) begin hit = 1; break; end
         @(negedge clk);
      end
      chk("reach_addr45", int'(hit), 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_wea_drop", int'(mem_wea), 0);
      chk("rst_ena_drop", int'(mem_ena), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      chk("rst_no_finish", fin_cnt - f0, 0);
      chk("rst_idle", int'(busy), 0);
      foreach (mem_img[i]) mem_img[i] = -1;
      run_tile(0, 0, 0);
      check_basic_image("post_reset_mem");

      // start while busy
      run_tile(0, 0, 1);
      check_basic_image("busy_start_mem");

      // randomized tiles
      for (int n = 0; n < 25; n++) random_tile();

      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
